ah_encoder_20_10: RTL and testbench
===================================

Name: ah_encoder_20_10

Overview:
- Transmit-side counterpart of the 10-bit/20-client range decoder.
- Arbitrates up to 20 client requests round-robin and encodes the winner into a 10-bit egress packet field. The field is {client index, 5-bit client offset}.
- Client i therefore always lands in decoder range [i*32, i*32+31].
- Sits at the client-side egress of the packet path. Registered output with valid/ready handshake toward the downstream decoder/fabric.

Parameters:
NUM_CLIENTS, 20, number of requesting clients (2..32)
FIELD_W, 10, width of egress_pkt_field
OFFSET_W, 5, per-client offset width; constraint NUM_CLIENTS*2^OFFSET_W <= 2^FIELD_W
IDX_W, 5, client index width, ceil(log2(NUM_CLIENTS))

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
client_req  input  NUM_CLIENTS  level request per client; held until granted
client_offset  input  NUM_CLIENTS*OFFSET_W  packed offsets; client i at bits [i*OFFSET_W +: OFFSET_W]
client_gnt  output  NUM_CLIENTS  one-hot grant pulse, combinational in the load cycle
egress_valid  output  1  egress_pkt_field holds a valid encoded field
egress_ready  input  1  downstream accepts when valid && ready
egress_pkt_field  output  FIELD_W  {zero pad, idx, offset} = idx*2^OFFSET_W + offset
egress_client_idx  output  IDX_W  index of the client encoded in the current field
enc_busy  output  1  high when egress_valid && !egress_ready (backpressure stall)

Behaviour:
- Reset (async assert, sync deassert in the surrounding domain):
  - egress_valid=0, egress_pkt_field=0, egress_client_idx=0, client_gnt=0, enc_busy=0.
  - RR pointer = 0, so client 0 has highest priority first.
- Output register has two states:
  - EMPTY (egress_valid=0).
  - FULL (egress_valid=1).
- load = (|client_req) && (EMPTY || (FULL && egress_ready)).
- On load:
  - Winner w = first requesting index at or after the RR pointer, wrapping modulo NUM_CLIENTS.
  - client_gnt[w]=1 that cycle only.
  - Next edge: egress_pkt_field <= w*2^OFFSET_W + offset[w], egress_client_idx <= w, egress_valid <= 1.
  - Next edge: RR pointer <= (w+1) mod NUM_CLIENTS; wrap 19 -> 0.
- Transfer with no load (FULL && egress_ready && no requests): next state EMPTY, egress_valid <= 0; field and idx keep their last values.
- FULL && !egress_ready:
  - Field, idx and valid are held stable.
  - client_gnt=0; RR pointer is unchanged.
  - enc_busy=1.
- Throughput: with ready tied high and requests pending, one field per cycle (back-to-back). Latency is 1 cycle from grant to egress_valid.
- Clients drop or refresh client_req on the cycle after client_gnt. A request held after grant is re-arbitrated normally and cannot starve others, because the pointer has advanced.
- Offset is sampled only in the grant cycle. Upper field bits above IDX_W+OFFSET_W are zero.
- Simultaneous transfer and new grant in the same cycle: state stays FULL and the new field replaces the old with no bubble.
- Reset mid-transfer: a pending field is discarded and not retransmitted.
- Invariants:
  - client_gnt is one-hot or zero.
  - client_gnt is never asserted when !load.
  - egress_pkt_field never changes while egress_valid && !egress_ready.

Test Plan:
- Reset check: hold rst_n=0 with client_req=20'hFFFFF -> client_gnt=0, egress_valid=0, field=0. Release -> first grant is client 0, field=10'd0+offset[0].
- Single client: client_req[7]=1, offset[7]=5'd3, ready=1 -> client_gnt[7] pulses once, next cycle field=10'd227, idx=7, valid=1.
- Round robin: all 20 requests held high, ready=1, offsets=0 -> grants 0,1,...,19,0 on consecutive cycles. Fields 0,32,...,608,0. No bubbles.
- Backpressure: client_req[3]|[5], ready=0 for 4 cycles after first load -> field=96 held for 4 cycles with enc_busy=1 and no client_gnt. On ready=1, the same cycle grants client 5; next field=160.
- Wrap priority: pointer at 19 after granting 18, requests {2,19} -> grants 19 then 2.
- Async reset mid-stall: assert rst_n=0 while valid=1, ready=0 -> egress_valid drops immediately without waiting for a clock edge. After release, the RR pointer restarts at 0.

Source files
------------

// File: rtl/ah_encoder_20_10.sv
// Round-robin request encoder: grants one of NUM_CLIENTS requesters and registers
// {client index, client offset} as an egress field behind a valid/ready handshake.
module ah_encoder_20_10 #(
  parameter int unsigned NUM_CLIENTS = 20,
  parameter int unsigned FIELD_W     = 10,
  parameter int unsigned OFFSET_W    = 5,
  parameter int unsigned IDX_W       = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CLIENTS-1:0]          client_req,
  input  logic [NUM_CLIENTS*OFFSET_W-1:0] client_offset,
  output logic [NUM_CLIENTS-1:0]          client_gnt,
  output logic                            egress_valid,
  input  logic                            egress_ready,
  output logic [FIELD_W-1:0]              egress_pkt_field,
  output logic [IDX_W-1:0]                egress_client_idx,
  output logic                            enc_busy
);

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FIELD_W-1:0]   field_q, field_d;
  logic [IDX_W-1:0]     win;
  logic [IDX_W:0]       cand;
  logic                 found;
  logic                 load;
  logic [OFFSET_W-1:0]  offs [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_offs
    assign offs[g] = client_offset[g*OFFSET_W +: OFFSET_W];
  end

  // Scan from the pointer upward, wrapping modulo NUM_CLIENTS; first hit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_CLIENTS)) cand = cand - (IDX_W+1)'(NUM_CLIENTS);
      if (!found && client_req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end

  // rst_n gating keeps the combinational grant quiet while reset is held.
  assign load = rst_n && found && ((state_q == ST_EMPTY) || egress_ready);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    field_d    = field_q;
    client_gnt = '0;
    if (load) begin
      client_gnt[win]           = 1'b1;
      state_d                   = ST_FULL;
      idx_d                     = win;
      field_d                   = '0;
      field_d[OFFSET_W +: IDX_W] = win;
      field_d[OFFSET_W-1:0]     = offs[win];
      ptr_d = (win == IDX_W'(NUM_CLIENTS-1)) ? '0 : win + 1'b1;
    end else if (state_q == ST_FULL && egress_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      idx_q   <= '0;
      field_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      field_q <= field_d;
    end
  end

  assign egress_valid      = (state_q == ST_FULL);
  assign enc_busy          = (state_q == ST_FULL) && !egress_ready;
  assign egress_pkt_field  = field_q;
  assign egress_client_idx = idx_q;

endmodule

// File: tb/tb_ah_encoder_20_10.sv
// Bench for ah_encoder_20_10: directed scenarios plus random traffic checked
// against an arithmetic round-robin model.
module tb_ah_encoder_20_10;

  localparam int N  = 20;
  localparam int OW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    client_req;
  logic [N*OW-1:0] client_offset;
  logic [N-1:0]    client_gnt;
  logic            egress_valid;
  logic            egress_ready;
  logic [9:0]      egress_pkt_field;
  logic [4:0]      egress_client_idx;
  logic            enc_busy;

  ah_encoder_20_10 #(.NUM_CLIENTS(20), .FIELD_W(10), .OFFSET_W(5), .IDX_W(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .client_req        (client_req),
    .client_offset     (client_offset),
    .client_gnt        (client_gnt),
    .egress_valid      (egress_valid),
    .egress_ready      (egress_ready),
    .egress_pkt_field  (egress_pkt_field),
    .egress_client_idx (egress_client_idx),
    .enc_busy          (enc_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_ptr, m_field, m_idx, last_w;
  bit m_full;

  logic [N-1:0] obs_gnt;
  logic [9:0]   obs_field;
  logic [4:0]   obs_idx;
  logic         obs_busy;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_field = 0; m_idx = 0; last_w = -1;
  endtask

  function automatic int offset_of(input int c);
    logic [N*OW-1:0] v;
    v = client_offset;
    return int'(v[c*OW +: OW]);
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    int w;
    bit ld;
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    if (!rst_n) model_reset();
    w = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (w < 0 && client_req[c]) w = c;
    end
    ld = rst_n && (w >= 0) && (!m_full || egress_ready);
    exp_gnt = '0;
    if (ld) exp_gnt[w] = 1'b1;
    obs_gnt = client_gnt; obs_field = egress_pkt_field;
    obs_idx = egress_client_idx; obs_busy = enc_busy;
    chk("gnt",   client_gnt, exp_gnt);
    chk("valid", egress_valid, m_full);
    chk("field", egress_pkt_field, m_field);
    chk("idx",   egress_client_idx, m_idx);
    chk("busy",  enc_busy, m_full && !egress_ready);
    if (ld) begin
      m_field = w * 32 + offset_of(w);
      m_idx   = w;
      m_full  = 1;
      m_ptr   = (w + 1) % N;
    end else if (m_full && egress_ready && rst_n) begin
      m_full = 0;
    end
    last_w = ld ? w : -1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_offsets();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    client_offset = r[N*OW-1:0];
  endtask

  initial begin
    rst_n = 1'b0;
    client_req = '1;
    egress_ready = 1'b1;
    rand_offsets();
    model_reset();

    // Reset held with every client requesting.
    step();
    step();
    chk("rst_gnt", obs_gnt, 0);
    chk("rst_field", obs_field, 0);
    rst_n = 1'b1;
    step();
    chk("rst_first_gnt", obs_gnt, 1);
    client_req = '0;
    step();
    chk("rst_first_field", obs_field, offset_of(0));
    step();

    // Single client.
    do_reset();
    client_req = N'(1) << 7;
    client_offset = '0;
    client_offset[7*OW +: OW] = 5'd3;
    step();
    chk("single_gnt", obs_gnt, 32'h80);
    client_req = '0;
    step();
    chk("single_field", obs_field, 227);
    chk("single_idx", obs_idx, 7);
    chk("single_gnt_once", obs_gnt, 0);
    step();

    // Back-to-back round robin.
    do_reset();
    client_req = '1;
    client_offset = '0;
    for (int i = 0; i < 21; i++) begin
      step();
      chk("rr_gnt", obs_gnt, 32'(1) << (i % N));
      if (i > 0) chk("rr_field", obs_field, ((i - 1) % N) * 32);
    end
    client_req = '0;
    step();
    step();

    // Backpressure.
    do_reset();
    client_req = (N'(1) << 3) | (N'(1) << 5);
    step();
    chk("bp_first_gnt", obs_gnt, 32'h8);
    client_req = N'(1) << 5;
    egress_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_field", obs_field, 96);
      chk("bp_busy", obs_busy, 1);
      chk("bp_no_gnt", obs_gnt, 0);
    end
    egress_ready = 1'b1;
    step();
    chk("bp_release_gnt", obs_gnt, 32'h20);
    client_req = '0;
    step();
    chk("bp_next_field", obs_field, 160);
    step();

    // Wrap priority.
    do_reset();
    client_req = N'(1) << 18;
    step();
    client_req = (N'(1) << 2) | (N'(1) << 19);
    step();
    chk("wrap_gnt19", obs_gnt, 32'h80000);
    client_req = N'(1) << 2;
    step();
    chk("wrap_gnt2", obs_gnt, 32'h4);
    client_req = '0;
    step();
    step();

    // Asynchronous reset during a stall.
    do_reset();
    client_req = N'(1) << 5;
    step();
    client_req = '0;
    egress_ready = 1'b0;
    step();
    chk("ar_valid_before", obs_field, 160 + offset_of(5));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_async", egress_valid, 0);
    chk("ar_field_async", egress_pkt_field, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    egress_ready = 1'b1;
    client_req = (N'(1) << 1) | (N'(1) << 7);
    step();
    chk("ar_ptr_restart", obs_gnt, 32'h2);
    client_req = N'(1) << 7;
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if (last_w >= 0 && $urandom_range(1, 0) == 1) client_req[last_w] = 1'b0;
      client_req = client_req | (N'($urandom()) & N'($urandom()) & N'($urandom()));
      egress_ready = ($urandom_range(3, 0) != 0);
      rand_offsets();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
